// File: rtl/hilbert_spec_framer_if.sv
// hilbert_spec_framer_if
//   Bundles the spectrum stream coming out of the forward FFT and the framed
//   stream going to the inverse FFT.
//   Signals:
//     ED      upstream enable; the input side acts only when ED=1
//     RDY_I   high on the ED cycle carrying bin k=0
//     DIR/DII input real/imag, signed, IN_BITS wide
//     ED_O    downstream enable; the output side acts only when ED_O=1
//     START_O high while the registered output is bin 0 of a frame
//     VAL_O   registered output sample valid
//     DOR/DOI output real/imag, signed, IN_BITS+1 wide
//     OVF     sticky flag: a whole frame was dropped because both banks were full
//   Modports: slave = the framer itself, master = whoever drives the input
//   side and consumes the output side.
interface hilbert_spec_framer_if #(
  parameter int IN_BITS = 36
);
  localparam int OUT_BITS = IN_BITS + 1;

  logic                       ED;
  logic                       RDY_I;
  logic signed [IN_BITS-1:0]  DIR;
  logic signed [IN_BITS-1:0]  DII;
  logic                       ED_O;
  logic                       START_O;
  logic                       VAL_O;
  logic signed [OUT_BITS-1:0] DOR;
  logic signed [OUT_BITS-1:0] DOI;
  logic                       OVF;

  modport slave (
    input  ED, RDY_I, DIR, DII, ED_O,
    output START_O, VAL_O, DOR, DOI, OVF
  );

  modport master (
    output ED, RDY_I, DIR, DII, ED_O,
    input  START_O, VAL_O, DOR, DOI, OVF
  );
endinterface

// File: rtl/hilbert_spec_framer.sv
// hilbert_spec_framer
//   Receiving end of the fft16 output stream in the Hilbert path. Each
//   16-bin spectrum (natural order) is masked to its analytic-signal form
//   while being written into one of two ping-pong banks, then replayed as a
//   START-framed stream towards the inverse FFT, which runs on ED_O.
//   Ports:
//     CLK  clock, all logic on the rising edge
//     RST  synchronous, active-high reset
//     bus  hilbert_spec_framer_if.slave (ED/RDY_I/DIR/DII in,
//          ED_O in, START_O/VAL_O/DOR/DOI/OVF out)
//   Parameters:
//     IN_BITS  width of each input real/imag sample
//     MASK_EN  1 = apply the Hilbert mask, 0 = sign-extend only
module hilbert_spec_framer #(
  parameter int IN_BITS = 36,
  parameter bit MASK_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  hilbert_spec_framer_if.slave bus
);
  localparam int OUT_BITS  = IN_BITS + 1;
  localparam int WORD_BITS = 2 * OUT_BITS;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_PLAY}         r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;
  logic [3:0] wcnt_reg, wcnt_next;
  logic [3:0] rcnt_reg, rcnt_next;
  logic       wbank_reg, wbank_next;
  logic       rbank_reg, rbank_next;
  logic [1:0] full_reg, full_next;
  logic       ovf_reg, ovf_next;

  // write-side controls
  logic       we;
  logic [3:0] waddr;
  logic       set_full;
  logic [OUT_BITS-1:0] wr_re, wr_im;

  // read-side controls
  logic       rd_load;
  logic       rd_zero;
  logic [3:0] raddr;
  logic       start_next;
  logic       clr_full;

  // two banks of 16 words; bank select is the address MSB
  logic [WORD_BITS-1:0] mem [0:31];

  // Analytic-signal mask: keep DC and Nyquist, double positive
  // frequencies, zero negative frequencies. Doubling is a plain shift
  // because the output is one bit wider than the input.
  function automatic logic [OUT_BITS-1:0] mask_bin(
    input logic [3:0]         k,
    input logic [IN_BITS-1:0] x
  );
    logic [OUT_BITS-1:0] res;
    res = {x[IN_BITS-1], x};
    if (MASK_EN) begin
      if (k == 4'd0 || k == 4'd8) begin
        res = {x[IN_BITS-1], x};
      end else if (k < 4'd8) begin
        res = {x, 1'b0};
      end else begin
        res = '0;
      end
    end
    return res;
  endfunction

  assign wr_re = mask_bin(waddr, bus.DIR);
  assign wr_im = mask_bin(waddr, bus.DII);

  // ---------------- write FSM ----------------
  always_comb begin
    w_state_next = w_state_reg;
    wcnt_next    = wcnt_reg;
    wbank_next   = wbank_reg;
    ovf_next     = ovf_reg;
    we           = 1'b0;
    waddr        = wcnt_reg;
    set_full     = 1'b0;
    if (bus.ED) begin
      if (bus.RDY_I) begin
        // bin 0 from any state: a frame in progress is abandoned and the
        // current bank is reused, so no separate restart path is needed
        waddr     = 4'd0;
        wcnt_next = 4'd1;
        if (full_reg[wbank_reg]) begin
          ovf_next     = 1'b1;
          w_state_next = W_DROP;
        end else begin
          we           = 1'b1;
          w_state_next = W_FILL;
        end
      end else begin
        case (w_state_reg)
          W_FILL: begin
            we        = 1'b1;
            wcnt_next = wcnt_reg + 4'd1;
            if (wcnt_reg == 4'd15) begin
              set_full     = 1'b1;
              wbank_next   = ~wbank_reg;
              w_state_next = W_IDLE;
            end
          end
          W_DROP: begin
            wcnt_next = wcnt_reg + 4'd1;
            if (wcnt_reg == 4'd15) begin
              w_state_next = W_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---------------- read FSM ----------------
  always_comb begin
    r_state_next = r_state_reg;
    rcnt_next    = rcnt_reg;
    rbank_next   = rbank_reg;
    rd_load      = 1'b0;
    rd_zero      = 1'b0;
    raddr        = rcnt_reg;
    start_next   = 1'b0;
    clr_full     = 1'b0;
    if (bus.ED_O) begin
      case (r_state_reg)
        R_IDLE: begin
          if (full_reg[rbank_reg]) begin
            rd_load      = 1'b1;
            raddr        = 4'd0;
            start_next   = 1'b1;
            rcnt_next    = 4'd1;
            r_state_next = R_PLAY;
          end else begin
            rd_zero = 1'b1;
          end
        end
        default: begin
          rd_load   = 1'b1;
          rcnt_next = rcnt_reg + 4'd1;
          if (rcnt_reg == 4'd15) begin
            clr_full     = 1'b1;
            rbank_next   = ~rbank_reg;
            r_state_next = R_IDLE;
          end
        end
      endcase
    end
  end

  // Per-bank full flags. Writer and reader never target the same bank in
  // one cycle (writing needs empty, reading needs full), so set and clear
  // cannot collide; each flag change becomes visible the next cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_next[gi] = (set_full && wbank_reg == 1'(gi)) ? 1'b1 :
                           (clr_full && rbank_reg == 1'(gi)) ? 1'b0 :
                           full_reg[gi];
  end

  // ---------------- state registers ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      wcnt_reg    <= 4'd0;
      rcnt_reg    <= 4'd0;
      wbank_reg   <= 1'b0;
      rbank_reg   <= 1'b0;
      full_reg    <= 2'b00;
      ovf_reg     <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      wcnt_reg    <= wcnt_next;
      rcnt_reg    <= rcnt_next;
      wbank_reg   <= wbank_next;
      rbank_reg   <= rbank_next;
      full_reg    <= full_next;
      ovf_reg     <= ovf_next;
    end
  end

  // sample store, no reset: contents are only trusted behind a full flag
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[{wbank_reg, waddr}] <= {wr_re, wr_im};
    end
  end

  // output register doubles as the registered RAM read
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.START_O <= 1'b0;
      bus.VAL_O   <= 1'b0;
      bus.DOR     <= '0;
      bus.DOI     <= '0;
    end else if (rd_load) begin
      {bus.DOR, bus.DOI} <= mem[{rbank_reg, raddr}];
      bus.START_O        <= start_next;
      bus.VAL_O          <= 1'b1;
    end else if (rd_zero) begin
      bus.START_O <= 1'b0;
      bus.VAL_O   <= 1'b0;
      bus.DOR     <= '0;
      bus.DOI     <= '0;
    end
  end

  assign bus.OVF = ovf_reg;
endmodule

// File: tb/tb_hilbert_spec_framer.sv
// tb_hilbert_spec_framer
//   Directed bench for hilbert_spec_framer. Expected output samples are
//   computed from the stimulus with a small mask model and queued as each
//   frame is driven; a monitor pops and compares every output sample taken
//   on an ED_O cycle. Prints one line per frame sent and per sample seen.
module tb_hilbert_spec_framer;
  localparam int IN_BITS  = 36;
  localparam int OUT_BITS = IN_BITS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilbert_spec_framer_if #(.IN_BITS(IN_BITS)) bus ();

  hilbert_spec_framer #(.IN_BITS(IN_BITS), .MASK_EN(1'b1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic                start;
    logic [OUT_BITS-1:0] re;
    logic [OUT_BITS-1:0] im;
  } samp_t;

  samp_t  exp_q[$];
  int     start_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     n_val  = 0;
  bit     mon_en = 1'b0;
  longint fr_re[16];
  longint fr_im[16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // analytic mask model written in integer arithmetic
  function automatic samp_t model(input int k, input longint re, input longint im, input bit start);
    samp_t  s;
    longint er, ei;
    if (k == 0 || k == 8) begin
      er = re;
      ei = im;
    end else if (k < 8) begin
      er = re * 2;
      ei = im * 2;
    end else begin
      er = 0;
      ei = 0;
    end
    s.start = start;
    s.re    = er[OUT_BITS-1:0];
    s.im    = ei[OUT_BITS-1:0];
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor / scoreboard
  initial begin
    logic  eo, r;
    samp_t e, got;
    forever begin
      @(posedge clk);
      eo = bus.ED_O;
      r  = rst;
      #1;
      if (mon_en && eo && !r && bus.VAL_O) begin
        n_val++;
        if (bus.START_O) start_q.push_back(cyc);
        got = {bus.START_O, bus.DOR, bus.DOI};
        $display("sample cyc=%0d start=%0b re=%0d im=%0d", cyc, bus.START_O, bus.DOR, bus.DOI);
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 128'(got), 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sample", 128'(got), 128'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit ed, input bit rdy, input longint re, input longint im);
    @(negedge clk);
    bus.ED    = ed;
    bus.RDY_I = rdy;
    bus.DIR   = re[IN_BITS-1:0];
    bus.DII   = im[IN_BITS-1:0];
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // sends fr_re/fr_im as one frame; tog inserts an ED=0 cycle (carrying
  // junk and RDY_I=1) before every bin after the first
  task automatic send_frame(input bit push, input bit tog, output int cap);
    cap = 0;
    for (int k = 0; k < 16; k++) begin
      if (tog && k > 0) drive(1'b0, 1'b1, 64'h5A5A_A5A5, -64'sd77);
      drive(1'b1, k == 0, fr_re[k], fr_im[k]);
      if (k == 0) cap = cyc + 1;
      if (push) exp_q.push_back(model(k, fr_re[k], fr_im[k], k == 0));
    end
    $display("frame sent cap=%0d push=%0b tog=%0b re0=%0d", cap, push, tog, fr_re[0]);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  initial begin
    int cap, bs, bv, lat;
    bus.ED = 1'b0; bus.RDY_I = 1'b0; bus.DIR = '0; bus.DII = '0; bus.ED_O = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({bus.START_O, bus.VAL_O, bus.DOR, bus.DOI, bus.OVF}), 128'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: single ramp frame, latency and end of valid
    for (int k = 0; k < 16; k++) begin fr_re[k] = k + 1; fr_im[k] = -(k + 1); end
    bs = start_q.size(); bv = n_val;
    send_frame(1'b1, 1'b0, cap);
    idle();
    drain(60);
    lat = (start_q.size() > bs) ? start_q[bs] - cap : -1;
    chk("latency_edges", 128'(lat), 128'd16);
    chk("frame1_count", 128'(n_val - bv), 128'd16);
    @(negedge clk);
    chk("val_low_after", 128'(bus.VAL_O), 128'd0);

    // 2: three back-to-back frames
    bs = start_q.size(); bv = n_val;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin fr_re[k] = 1000 * (f + 1) + k; fr_im[k] = -3 * k - f; end
      send_frame(1'b1, 1'b0, cap);
    end
    idle();
    drain(100);
    chk("b2b_val_count", 128'(n_val - bv), 128'd48);
    chk("b2b_start_count", 128'(start_q.size() - bs), 128'd3);
    if (start_q.size() >= bs + 3) begin
      chk("b2b_gap1", 128'(start_q[bs + 1] - start_q[bs]), 128'd16);
      chk("b2b_gap2", 128'(start_q[bs + 2] - start_q[bs + 1]), 128'd16);
    end
    chk("b2b_ovf", 128'(bus.OVF), 128'd0);

    // 3: signed extremes
    for (int k = 0; k < 16; k++) begin fr_re[k] = 7 * k - 50; fr_im[k] = 11 - k; end
    fr_re[3]  = -(64'sd1 <<< (IN_BITS - 1));
    fr_re[8]  = -(64'sd1 <<< (IN_BITS - 1));
    fr_re[12] = -(64'sd1 <<< (IN_BITS - 1));
    fr_im[3]  = (64'sd1 <<< (IN_BITS - 1)) - 1;
    fr_im[8]  = (64'sd1 <<< (IN_BITS - 1)) - 1;
    send_frame(1'b1, 1'b0, cap);
    idle();
    drain(60);

    // 4: downstream stalled while three frames arrive; third is dropped
    @(negedge clk);
    bus.ED_O = 1'b0;
    bs = start_q.size(); bv = n_val;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin fr_re[k] = -500 * (f + 1) + k; fr_im[k] = 40 * f + k; end
      send_frame(f < 2, 1'b0, cap);
    end
    idle();
    repeat (4) @(negedge clk);
    chk("ovf_set", 128'(bus.OVF), 128'd1);
    chk("stall_no_output", 128'(n_val - bv), 128'd0);
    bus.ED_O = 1'b1;
    drain(100);
    chk("stall_val_count", 128'(n_val - bv), 128'd32);
    chk("stall_start_count", 128'(start_q.size() - bs), 128'd2);
    chk("ovf_sticky", 128'(bus.OVF), 128'd1);

    // 5: restart at bin 9
    bs = start_q.size(); bv = n_val;
    for (int k = 0; k < 9; k++) drive(1'b1, k == 0, 64'sd90000 + k, -64'sd90000);
    for (int k = 0; k < 16; k++) begin fr_re[k] = 300 - k; fr_im[k] = 5 * k; end
    send_frame(1'b1, 1'b0, cap);
    idle();
    drain(60);
    @(negedge clk);
    chk("restart_count", 128'(n_val - bv), 128'd16);
    chk("restart_starts", 128'(start_q.size() - bs), 128'd1);

    // 6: ED toggling during the write
    for (int k = 0; k < 16; k++) begin fr_re[k] = k + 1; fr_im[k] = -(k + 1); end
    send_frame(1'b1, 1'b1, cap);
    idle();
    drain(80);

    // 7: reset in the middle of replay
    @(negedge clk);
    mon_en = 1'b0;
    for (int k = 0; k < 16; k++) begin fr_re[k] = 2000 + k; fr_im[k] = k; end
    send_frame(1'b0, 1'b0, cap);
    idle();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", 128'({bus.START_O, bus.VAL_O, bus.DOR, bus.DOI, bus.OVF}), 128'd0);
    repeat (3) @(negedge clk);
    chk("rst_discard", 128'(bus.VAL_O), 128'd0);
    mon_en = 1'b1;
    bs = start_q.size(); bv = n_val;
    for (int k = 0; k < 16; k++) begin fr_re[k] = -k - 3; fr_im[k] = 2 * k + 1; end
    send_frame(1'b1, 1'b0, cap);
    idle();
    drain(60);
    chk("post_rst_count", 128'(n_val - bv), 128'd16);
    chk("post_rst_starts", 128'(start_q.size() - bs), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
